// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, byte width and default limits.
package uart_pkg;

  localparam int BYTE_W            = 8;
  localparam int DEFAULT_MAX_BURST = 16;
  localparam int DEFAULT_TIMEOUT   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Increment with explicit wrap so non-power-of-two requester counts work.
  function automatic int wrap_inc(input int value, input int modulus);
    if (value + 1 >= modulus) return 0;
    return value + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or above ptr, with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] index
);

  localparam int SW = IW + 1;

  // Walk the requesters starting at ptr; the first hit wins and later hits are ignored.
  always_comb begin
    logic [SW-1:0] sum;
    logic [IW-1:0] cand;
    logic          found;
    winner = '0;
    index  = '0;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        index        = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ message sources, granting whole
// messages round-robin, bounded by a burst-length cap and an idle timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      tx_busy,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      new_tx_data
);

  localparam int IW = $clog2(NUM_REQ);

  state_t              state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       owner;
  logic [7:0]          byte_cnt;
  logic [7:0]          idle_cnt;
  logic                release_pending;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IW-1:0]       pick_index;
  logic                owner_req;
  logic                owner_last;
  logic [BYTE_W-1:0]   owner_byte;
  logic [7:0]          byte_cnt_next;
  logic [7:0]          idle_cnt_next;
  logic [IW-1:0]       ptr_after_owner;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_onehot),
    .index  (pick_index)
  );

  // Route the current owner's request, last flag and byte out of the flat buses.
  always_comb begin
    owner_req  = 1'b0;
    owner_last = 1'b0;
    owner_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IW'(i)) begin
        owner_req  = req[i];
        owner_last = req_last[i];
        owner_byte = req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign byte_cnt_next   = byte_cnt + 8'd1;
  assign idle_cnt_next   = idle_cnt + 8'd1;
  assign ptr_after_owner = IW'(wrap_inc(int'(owner), NUM_REQ));

  // Arbiter FSM with registered outputs. A burst ending on last byte or cap is
  // released at the end of the following SETTLE cycle, so grant still covers
  // the cycle in which that final byte is strobed and acknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      owner           <= '0;
      byte_cnt        <= '0;
      idle_cnt        <= '0;
      release_pending <= 1'b0;
      grant           <= '0;
      req_ack         <= '0;
      new_tx_data     <= 1'b0;
      tx_data         <= '0;
    end else begin
      new_tx_data <= 1'b0;
      req_ack     <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant           <= pick_onehot;
            owner           <= pick_index;
            byte_cnt        <= '0;
            idle_cnt        <= '0;
            release_pending <= 1'b0;
            state           <= SEND;
          end
        end
        SEND: begin
          if (owner_req) begin
            idle_cnt <= '0;
            if (!tx_busy) begin
              tx_data         <= owner_byte;
              new_tx_data     <= 1'b1;
              req_ack         <= grant;
              byte_cnt        <= byte_cnt_next;
              release_pending <= owner_last || (byte_cnt_next == 8'(MAX_BURST));
              state           <= SETTLE;
            end
          end else if (idle_cnt_next == 8'(TIMEOUT)) begin
            grant    <= '0;
            ptr      <= ptr_after_owner;
            idle_cnt <= '0;
            state    <= IDLE;
          end else begin
            idle_cnt <= idle_cnt_next;
          end
        end
        SETTLE: begin
          if (release_pending) begin
            grant           <= '0;
            ptr             <= ptr_after_owner;
            release_pending <= 1'b0;
            state           <= IDLE;
          end else begin
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: cycle table, directed corner cases,
// then randomized traffic checked against a message-level reference model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 16;
  localparam int TIMEOUT   = 32;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ack;
  logic [3:0]  grant;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        new_tx_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic        busy;
    logic [3:0]  exp_grant;
    logic        exp_new;
    logic [7:0]  exp_data;
    logic [3:0]  exp_ack;
  } vec_t;

  vec_t vecs[13];

  logic [8:0] items[4][128];
  int         head[4];
  int         len[4];
  int         gap[4];
  int         msg_len;
  int         mptr;
  int         burst;
  int         own;
  int         exp_idx;
  int         cnt;
  int         k;
  logic [3:0] prev_grant;
  logic       exp_rel;

  uart_tx_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ack     (req_ack),
    .grant       (grant),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic [31:0] d,
                                input logic [3:0] l, input logic b);
    req      = r;
    req_data = d;
    req_last = l;
    tx_busy  = b;
  endtask

  task automatic check_output(input string tag, input logic [3:0] g, input logic n,
                              input logic [7:0] d, input logic [3:0] a);
    check({tag, " grant"}, 32'(grant), 32'(g));
    check({tag, " new_tx_data"}, 32'(new_tx_data), 32'(n));
    check({tag, " tx_data"}, 32'(tx_data), 32'(d));
    check({tag, " req_ack"}, 32'(req_ack), 32'(a));
  endtask

  task automatic wait_grant(input logic [3:0] exp, input string name);
    for (int i = 0; i < 100 && grant !== exp; i++) step();
    check(name, 32'(grant), 32'(exp));
  endtask

  task automatic wait_strobe(input string name);
    int i;
    i = 0;
    do begin
      step();
      i++;
    end while (new_tx_data !== 1'b1 && i < 100);
    check(name, 32'(new_tx_data), 32'd1);
  endtask

  // Reference: first requesting index at or after p, wrapping modulo 4.
  function automatic int rr_expect(input logic [3:0] r, input int p);
    for (int j = 0; j < 4; j++) begin
      if (r[(p + j) % 4]) return (p + j) % 4;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [3:0] v);
    for (int j = 0; j < 4; j++) if (v[j]) return j;
    return -1;
  endfunction

  // Each random source presents the head of its own message list, with
  // occasional short pauses after an acknowledged byte.
  task automatic drive_random();
    for (int i = 0; i < 4; i++) begin
      if (gap[i] > 0) begin
        req[i] = 1'b0;
        gap[i]--;
      end else begin
        req[i] = (head[i] < len[i]);
      end
      if (head[i] < len[i]) begin
        req_data[i*8 +: 8] = items[i][head[i]][7:0];
        req_last[i]        = items[i][head[i]][8];
      end else begin
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    tx_busy = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    // Cycle table: row k inputs are held during cycle k, outputs checked in cycle k+1.
    vecs[0]  = '{4'b0010, 32'h0000_4800, 4'b0000, 1'b0, 4'b0010, 1'b0, 8'h00, 4'b0000};
    vecs[1]  = '{4'b0010, 32'h0000_4800, 4'b0000, 1'b0, 4'b0010, 1'b1, 8'h48, 4'b0010};
    vecs[2]  = '{4'b0010, 32'h0000_4800, 4'b0000, 1'b1, 4'b0010, 1'b0, 8'h48, 4'b0000};
    vecs[3]  = '{4'b0010, 32'h0000_4900, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h49, 4'b0010};
    vecs[4]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h49, 4'b0000};
    vecs[5]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h49, 4'b0000};
    vecs[6]  = '{4'b1001, 32'hD300_00A0, 4'b1001, 1'b0, 4'b1000, 1'b0, 8'h49, 4'b0000};
    vecs[7]  = '{4'b1001, 32'hD300_00A0, 4'b1001, 1'b0, 4'b1000, 1'b1, 8'hD3, 4'b1000};
    vecs[8]  = '{4'b1001, 32'hD300_00A0, 4'b1001, 1'b0, 4'b0000, 1'b0, 8'hD3, 4'b0000};
    vecs[9]  = '{4'b0001, 32'h0000_00A0, 4'b0001, 1'b0, 4'b0001, 1'b0, 8'hD3, 4'b0000};
    vecs[10] = '{4'b0001, 32'h0000_00A0, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA0, 4'b0001};
    vecs[11] = '{4'b0001, 32'h0000_00A0, 4'b0001, 1'b0, 4'b0000, 1'b0, 8'hA0, 4'b0000};
    vecs[12] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA0, 4'b0000};

    rst = 1'b1;
    apply_stimulus(4'b0000, 32'h0, 4'b0000, 1'b0);
    step();
    step();
    check_output("reset", 4'b0000, 1'b0, 8'h00, 4'b0000);
    rst = 1'b0;

    for (int v = 0; v < 13; v++) begin
      apply_stimulus(vecs[v].req, vecs[v].data, vecs[v].last, vecs[v].busy);
      step();
      check_output($sformatf("vec%0d", v), vecs[v].exp_grant, vecs[v].exp_new,
                   vecs[v].exp_data, vecs[v].exp_ack);
    end

    // Busy stall: transmitter busy for 10 cycles right after a strobe.
    apply_stimulus(4'b0001, 32'h0000_0010, 4'b0000, 1'b0);
    wait_grant(4'b0001, "stall grant");
    wait_strobe("stall first strobe");
    check("stall first byte", 32'(tx_data), 32'h10);
    tx_busy = 1'b1;
    step();
    check("stall quiet 0", 32'(new_tx_data), 32'd0);
    req_data = 32'h0000_0011;
    for (int i = 1; i < 10; i++) begin
      step();
      check($sformatf("stall quiet %0d", i), 32'(new_tx_data), 32'd0);
    end
    tx_busy = 1'b0;
    step();
    check("stall resume strobe", 32'(new_tx_data), 32'd1);
    check("stall resume byte", 32'(tx_data), 32'h11);
    check("stall grant held", 32'(grant), 32'h1);
    step();
    req_data = 32'h0000_0012;
    req_last = 4'b0001;
    wait_strobe("stall last strobe");
    check("stall last byte", 32'(tx_data), 32'h12);
    apply_stimulus(4'b0000, 32'h0, 4'b0000, 1'b0);
    step();
    check("stall release", 32'(grant), 32'h0);

    // Timeout: owner goes quiet after one byte.
    apply_stimulus(4'b0100, 32'h0022_0000, 4'b0000, 1'b0);
    wait_grant(4'b0100, "timeout grant");
    wait_strobe("timeout strobe");
    check("timeout byte", 32'(tx_data), 32'h22);
    req = 4'b0000;
    for (int i = 0; i < TIMEOUT; i++) step();
    check("timeout hold", 32'(grant), 32'h4);
    step();
    check("timeout release", 32'(grant), 32'h0);
    apply_stimulus(4'b1100, 32'h3322_0000, 4'b1000, 1'b0);
    step();
    check("timeout ptr advance", 32'(grant), 32'h8);
    req = 4'b1000;
    wait_strobe("timeout next strobe");
    check("timeout next byte", 32'(tx_data), 32'h33);
    req = 4'b0000;
    step();
    check("timeout next release", 32'(grant), 32'h0);

    // Burst cap: source 3 streams past the cap while source 0 waits.
    apply_stimulus(4'b1000, 32'h3000_0000, 4'b0000, 1'b0);
    wait_grant(4'b1000, "cap grant");
    apply_stimulus(4'b1001, 32'h3000_000F, 4'b0001, 1'b0);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (new_tx_data && req_ack == 4'b1000) begin
        check($sformatf("cap byte %0d", cnt), 32'(tx_data), 32'(8'(8'h30 + cnt)));
        cnt++;
        req_data[31:24] = 8'(8'h30 + cnt);
        if (cnt == MAX_BURST) req_last[3] = 1'b1;
      end
      if (grant == 4'b0001) break;
    end
    check("cap bytes before handover", 32'(cnt), 32'(MAX_BURST));
    check("cap handover", 32'(grant), 32'h1);
    wait_strobe("cap waiter strobe");
    check("cap waiter byte", 32'(tx_data), 32'h0F);
    req[0] = 1'b0;
    wait_grant(4'b1000, "cap resume grant");
    wait_strobe("cap resume strobe");
    check("cap resume byte", 32'(tx_data), 32'h40);
    req = 4'b0000;
    step();
    check("cap final release", 32'(grant), 32'h0);

    // Round-robin: sources 0 and 2 request continuously with 1-byte messages.
    apply_stimulus(4'b0101, 32'h00C2_00C0, 4'b0101, 1'b0);
    k = 0;
    prev_grant = grant;
    for (int i = 0; i < 300 && k < 6; i++) begin
      step();
      if (prev_grant == 4'b0000 && grant != 4'b0000) begin
        check($sformatf("rr grant %0d", k), 32'(grant), (k % 2 == 0) ? 32'h1 : 32'h4);
        k++;
      end
      prev_grant = grant;
    end
    check("rr grant count", 32'(k), 32'd6);
    req = 4'b0100;
    wait_strobe("rr last strobe");
    req = 4'b0000;
    step();
    check("rr release", 32'(grant), 32'h0);

    // Reset during SETTLE drops everything and returns the pointer to 0.
    apply_stimulus(4'b1000, 32'h7700_0000, 4'b0000, 1'b0);
    wait_grant(4'b1000, "rstmid grant");
    wait_strobe("rstmid strobe");
    rst = 1'b1;
    step();
    check_output("rstmid", 4'b0000, 1'b0, 8'h00, 4'b0000);
    rst = 1'b0;
    apply_stimulus(4'b1010, 32'h7700_5500, 4'b1010, 1'b0);
    step();
    check("rstmid ptr zero", 32'(grant), 32'h2);
    rst = 1'b1;
    apply_stimulus(4'b0000, 32'h0, 4'b0000, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Randomized traffic against the message-level model.
    for (int i = 0; i < 4; i++) begin
      len[i]  = 0;
      head[i] = 0;
      gap[i]  = 0;
      for (int m = 0; m < 5; m++) begin
        msg_len = $urandom_range(1, 22);
        for (int b = 0; b < msg_len; b++) begin
          items[i][len[i]] = {(b == msg_len - 1), 8'($urandom)};
          len[i]++;
        end
      end
    end
    mptr       = 0;
    burst      = 0;
    exp_rel    = 1'b0;
    prev_grant = 4'b0000;
    drive_random();
    for (int c = 0; c < 3000; c++) begin
      step();
      check("rand grant onehot", 32'($onehot0(grant)), 32'd1);
      if (exp_rel) check("rand release", 32'(grant), 32'h0);
      exp_rel = 1'b0;
      if (prev_grant == 4'b0000 && grant != 4'b0000) begin
        exp_idx = rr_expect(req, mptr);
        check("rand rr pick", 32'(grant), (exp_idx < 0) ? 32'h0 : (32'h1 << exp_idx));
        burst = 0;
      end else if (prev_grant != 4'b0000 && grant != 4'b0000 && grant != prev_grant) begin
        check("rand grant switch", 32'(grant), 32'(prev_grant));
      end
      if (prev_grant != 4'b0000 && grant == 4'b0000) mptr = (idx_of(prev_grant) + 1) % 4;
      if (new_tx_data) begin
        check("rand ack vs grant", 32'(req_ack), 32'(grant));
        own = idx_of(req_ack);
        if (own >= 0 && head[own] < len[own]) begin
          check("rand byte", 32'(tx_data), 32'(items[own][head[own]][7:0]));
          burst++;
          check("rand burst cap", 32'(burst <= MAX_BURST), 32'd1);
          if (items[own][head[own]][8] || burst == MAX_BURST) exp_rel = 1'b1;
          head[own]++;
          gap[own] = $urandom_range(0, 2);
        end
      end else begin
        check("rand ack idle", 32'(req_ack), 32'h0);
      end
      prev_grant = grant;
      drive_random();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter (`tx_data`/`new_tx_data`/`tx_busy` handshake) between `NUM_REQ` message sources such as message printers and status reporters. It grants the transmitter to one source for a whole message (burst), using round-robin priority. A burst-length cap and an idle timeout keep any one source from holding the transmitter. The block sits between the message sources and the serial transmitter.

## Interface
- `NUM_REQ`, 4: number of requesters (2–8).
- `MAX_BURST`, 16: maximum bytes per grant (1–255).
- `TIMEOUT`, 32: consecutive cycles the owner's `req` may stay low mid-burst before the grant is revoked (1–255).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req` in `NUM_REQ`: per-source "byte available".
- `req_data` in `8*NUM_REQ`: byte of source i on bits [8i+7:8i].
- `req_last` in `NUM_REQ`: the presented byte ends the message.
- `req_ack` out `NUM_REQ`: one-cycle pulse; the byte of that source was consumed.
- `grant` out `NUM_REQ`: one-hot current owner; all zero when idle.
- `tx_busy` in 1: transmitter busy.
- `tx_data` out 8: byte to the transmitter.
- `new_tx_data` out 1: one-cycle strobe, `tx_data` valid.

## Operation
- All outputs are registered. Reset values: `tx_data`=0, `new_tx_data`=0, `req_ack`=0, `grant`=0.
- Internal reset values: state=IDLE, rr pointer=0, byte count=0, idle count=0.
- `rst` overrides everything. Reset mid-burst drops the grant immediately and issues no strobe or ack.

State machine: IDLE, SEND, SETTLE.
- **IDLE**
  - If `req` is nonzero, grant the first requester at or above the rr pointer, searching with wrap (modulo `NUM_REQ`).
  - Clear both counters and go to SEND.
- **SEND**
  - If `req[owner]`=1 and `tx_busy`=0, issue a byte:
    - next cycle: `tx_data`=owner byte, `new_tx_data`=1, `req_ack[owner]`=1;
    - byte count +1.
  - After issuing, if `req_last[owner]`=1 or the new byte count equals `MAX_BURST`, release. Otherwise go to SETTLE.
  - If `req[owner]`=0, idle count +1. When it reaches `TIMEOUT`, release.
  - Idle count clears whenever `req[owner]`=1.
  - If `req[owner]`=1 and `tx_busy`=1, wait. Idle count does not advance.
- **SETTLE**
  - One cycle, with `tx_busy` ignored. This covers the transmitter's one-cycle busy-assert delay.
  - Then go to SEND.
- **Release**
  - `grant`→0 next cycle, state→IDLE.
  - rr pointer = (owner+1) mod `NUM_REQ`.
- Simultaneous last byte and byte-count cap: a single release.
- Width and arithmetic rules:
  - Byte count is 8 bits and saturates by construction, since release occurs at `MAX_BURST`.
  - Pointer wrap is explicit modulo `NUM_REQ` (non-power-of-2 values are legal).
- Requests from non-owners are ignored until IDLE. Changes to `req_data` from non-owners have no effect.
- Sources must present the next byte on the cycle after `req_ack`. `req_data`/`req_last` must be stable while `req` is high and unacked.

## Timing
- From `req` rising in IDLE (cycle 0):
  - `grant` high in cycle 1;
  - earliest `new_tx_data` in cycle 2.
- Back-to-back bytes, transmitter never busy: one strobe every 2 cycles (SEND, SETTLE).
- `req_ack` and `new_tx_data` are coincident, single-cycle pulses.
- After release there is at least one IDLE cycle before the next grant.
- Worst-case wait for a requester: (`NUM_REQ`−1) bursts, each bounded by `MAX_BURST` bytes or `TIMEOUT` idle cycles.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, SEND, SETTLE);
  - byte width constant 8;
  - default `MAX_BURST`/`TIMEOUT` constants, reused by future UART blocks.
- Sub-module `rr_pick`: combinational round-robin one-hot selector. Inputs are `req` and the pointer; outputs are the one-hot winner and its index. It is kept separate so it can be unit-tested and reused by an RX dispatcher.

## Test plan
- `NUM_REQ`=4, `MAX_BURST`=16, `TIMEOUT`=32 unless stated.
- **Single source:** source 1 sends "HI" (`req_last` on 'I'), `tx_busy`=0 → `grant`=0010 at cycle 1, `new_tx_data` at cycles 2 and 4 with 0x48 then 0x49, `grant`=0 at cycle 5.
- **Round-robin:** sources 0 and 2 request continuously with 1-byte messages → grants alternate 0, 2, 0, 2, and a source never gets consecutive grants while the other waits.
- **Busy stall:** `tx_busy` held high for 10 cycles after a strobe → no strobe while busy; the next strobe occurs 1 cycle after `tx_busy` falls; idle count stays 0.
- **Burst cap:** `MAX_BURST`=3, source 3 streams 5 bytes without last → 3 strobes, release, source 0 (waiting) granted next; source 3's remaining bytes are sent on a later grant.
- **Timeout:** owner drops `req` after 1 byte → `grant` clears exactly 32 cycles later, pointer advances.
- **Reset mid-burst:** assert `rst` during SETTLE → all outputs 0 next cycle, and the next grant goes to the lowest-index requester (pointer=0).
